blowfish_block_packer: RTL and testbench

Upstream stage of blowfish_encryption. Accepts a byte stream with valid/ready handshake and message-end marker. Packs bytes big-endian into 64-bit blocks and applies PKCS#7 padding at message end. Presents each completed block, held stable, on the 64-bit plainText input of the encryption core.

---
 rtl/blowfish_pkg.sv | 19 +
 rtl/blowfish_block_packer_if.sv | 25 ++
 rtl/blowfish_block_packer_pad_gen.sv | 23 ++
 rtl/blowfish_block_packer.sv | 121 ++++++++++++
 tb/tb_blowfish_block_packer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/blowfish_pkg.sv
// Shared constants and types for the Blowfish datapath.
// Used by the byte packer and the encryption core.
package blowfish_pkg;

    localparam int BLOCK_W         = 64;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 8;

    localparam logic [BLOCK_W-1:0] PAD_FULL_BLOCK = 64'h0808080808080808;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        HOLD_PAD
    } pk_state_e;

endpackage

// File: rtl/blowfish_block_packer_if.sv
// Byte-stream in / block-out handshake bundle of the packer.
interface blowfish_block_packer_if;
    import blowfish_pkg::*;

    logic [BYTE_W-1:0] in_byte;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    block_t            out_block;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [3:0]        out_pad_len;

    modport slave (
        input  in_byte, in_valid, in_last, out_ready,
        output in_ready, out_block, out_valid, out_last, out_pad_len
    );

    modport master (
        output in_byte, in_valid, in_last, out_ready,
        input  in_ready, out_block, out_valid, out_last, out_pad_len
    );

endinterface

// File: rtl/blowfish_block_packer_pad_gen.sv
// Fills the tail of a partial block: pad value 8-n, or zeros.
module blowfish_pad_gen
    import blowfish_pkg::*;
(
    input  block_t     partial,
    input  logic [3:0] n,
    input  logic       pad_en,
    output block_t     padded,
    output logic [3:0] pad_len
);

    always_comb begin
        pad_len = 4'd8 - n;
        padded  = partial;
        for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
            if (k >= int'(n)) begin
                padded[BLOCK_W-1-BYTE_W*k -: BYTE_W] =
                    pad_en ? {4'd0, pad_len} : '0;
            end
        end
    end

endmodule

// File: rtl/blowfish_block_packer.sv
// Packs a byte stream big-endian into 64-bit blocks with PKCS#7 or zero fill.
module blowfish_block_packer
    import blowfish_pkg::*;
#(
    parameter bit PAD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    blowfish_block_packer_if.slave bus,
    output logic [CNT_W-1:0]       blk_count
);

    pk_state_e        state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    block_t           blk_q, blk_d;
    logic             last_q, last_d;
    logic [3:0]       pad_q, pad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    block_t     ins;
    block_t     padded;
    logic [3:0] n;
    logic [3:0] fill_len;
    logic       acc;

    assign bus.in_ready    = (state_q == FILL) & ~rst;
    assign bus.out_valid   = (state_q != FILL);
    assign bus.out_block   = blk_q;
    assign bus.out_last    = last_q;
    assign bus.out_pad_len = pad_q;
    assign blk_count       = cnt_q;

    assign acc = bus.in_valid & bus.in_ready;
    assign n   = {1'b0, idx_q} + 4'd1;

    always_comb begin
        ins = blk_q;
        ins[BLOCK_W-1-BYTE_W*int'(idx_q) -: BYTE_W] = bus.in_byte;
    end

    blowfish_pad_gen u_pad (
        .partial (ins),
        .n       (n),
        .pad_en  (PAD_EN),
        .padded  (padded),
        .pad_len (fill_len)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        last_d  = last_q;
        pad_d   = pad_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FILL: begin
                if (acc) begin
                    blk_d = ins;
                    idx_d = idx_q + 3'd1;
                    if (bus.in_last) begin
                        idx_d = '0;
                        if (idx_q != 3'd7) begin
                            blk_d   = padded;
                            pad_d   = fill_len;
                            last_d  = 1'b1;
                            state_d = HOLD;
                        end else begin
                            pad_d   = '0;
                            last_d  = !PAD_EN;
                            state_d = PAD_EN ? HOLD_PAD : HOLD;
                        end
                    end else if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        pad_d   = '0;
                        last_d  = 1'b0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    idx_d   = '0;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = FILL;
                end
            end
            HOLD_PAD: begin
                // Extra all-pad block follows with no valid gap
                if (bus.out_ready) begin
                    blk_d   = PAD_FULL_BLOCK;
                    pad_d   = 4'd8;
                    last_d  = 1'b1;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = HOLD;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            pad_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_blowfish_block_packer.sv
// Directed bench: PAD_EN=0 (16-bit count) and PAD_EN=1 (3-bit count) packers.
module tb_blowfish_block_packer;
    import blowfish_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blowfish_block_packer_if if0 ();
    blowfish_block_packer_if if1 ();

    logic [15:0] bc0;
    logic [2:0]  bc1;

    blowfish_block_packer #(.PAD_EN(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .blk_count(bc0));
    blowfish_block_packer #(.PAD_EN(1'b1), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .blk_count(bc1));

    logic       iv[2], il[2], ordy[2];
    logic [7:0] ib[2];
    logic       irdy[2], ov[2], ol[2];
    logic [63:0] ob[2];
    logic [3:0]  op[2];
    logic [15:0] bc[2];

    assign if0.in_valid = iv[0];
    assign if0.in_last = il[0];
    assign if0.in_byte = ib[0];
    assign if0.out_ready = ordy[0];
    assign if1.in_valid = iv[1];
    assign if1.in_last = il[1];
    assign if1.in_byte = ib[1];
    assign if1.out_ready = ordy[1];
    assign irdy[0] = if0.in_ready;
    assign irdy[1] = if1.in_ready;
    assign ov[0] = if0.out_valid;
    assign ov[1] = if1.out_valid;
    assign ol[0] = if0.out_last;
    assign ol[1] = if1.out_last;
    assign ob[0] = if0.out_block;
    assign ob[1] = if1.out_block;
    assign op[0] = if0.out_pad_len;
    assign op[1] = if1.out_pad_len;
    assign bc[0] = bc0;
    assign bc[1] = {13'd0, bc1};

    int checks = 0;
    int errors = 0;
    int cexp[2];

    typedef struct {
        int          d;
        int          n;
        logic [63:0] bytes;
        logic        lst;
        logic [63:0] exp;
        logic        exp_last;
        logic [3:0]  exp_pad;
        logic        two;
    } vec_t;

    vec_t tv[7];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(string nm, int d);
        logic [15:0] m;
        m = (d == 1) ? 16'h0007 : 16'hFFFF;
        chk(nm, {48'd0, bc[d]}, {48'd0, 16'(cexp[d]) & m});
    endtask

    task automatic send(int d, logic [7:0] b, logic l);
        int t;
        iv[d] = 1'b1;
        ib[d] = b;
        il[d] = l;
        t = 0;
        while (!irdy[d] && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!irdy[d]) chk("in_ready_wait", {63'd0, irdy[d]}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
        il[d] = 1'b0;
    endtask

    task automatic take(int d);
        ordy[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[d] = 1'b0;
        cexp[d]++;
    endtask

    task automatic chk_out(string nm, int d, logic [63:0] e,
                           logic el, logic [3:0] ep);
        chk({nm, "_valid"}, {63'd0, ov[d]}, 64'd1);
        chk({nm, "_block"}, ob[d], e);
        chk({nm, "_last"}, {63'd0, ol[d]}, {63'd0, el});
        chk({nm, "_pad"}, {60'd0, op[d]}, {60'd0, ep});
    endtask

    initial begin
        logic [63:0] held;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 0; il[d] = 0; ordy[d] = 0; ib[d] = 0; cexp[d] = 0;
        end

        tv[0] = '{1, 8, 64'h0102030405060708, 1'b0,
                  64'h0102030405060708, 1'b0, 4'd0, 1'b0};
        tv[1] = '{1, 5, 64'hF0F0FA322C000000, 1'b1,
                  64'hF0F0FA322C030303, 1'b1, 4'd3, 1'b0};
        tv[2] = '{1, 8, 64'h1112131415161718, 1'b1,
                  64'h1112131415161718, 1'b0, 4'd0, 1'b1};
        tv[3] = '{0, 8, 64'h1112131415161718, 1'b1,
                  64'h1112131415161718, 1'b1, 4'd0, 1'b0};
        tv[4] = '{0, 1, 64'hAA00000000000000, 1'b1,
                  64'hAA00000000000000, 1'b1, 4'd7, 1'b0};
        tv[5] = '{1, 1, 64'hAA00000000000000, 1'b1,
                  64'hAA07070707070707, 1'b1, 4'd7, 1'b0};
        tv[6] = '{0, 3, 64'h0102030000000000, 1'b1,
                  64'h0102030000000000, 1'b1, 4'd5, 1'b0};

        @(negedge clk);
        chk("rst_in_ready", {63'd0, irdy[1]}, 64'd0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_valid", d), {63'd0, ov[d]}, 64'd0);
            chk($sformatf("rst%0d_block", d), ob[d], 64'd0);
            chk_cnt($sformatf("rst%0d_cnt", d), d);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            int d;
            d = tv[v].d;
            for (int j = 0; j < tv[v].n; j++)
                send(d, tv[v].bytes[63-8*j -: 8],
                     tv[v].lst && (j == tv[v].n - 1));
            chk_out($sformatf("v%0d", v), d, tv[v].exp,
                    tv[v].exp_last, tv[v].exp_pad);
            take(d);
            if (tv[v].two) begin
                chk_out($sformatf("v%0d_pad", v), d, PAD_FULL_BLOCK,
                        1'b1, 4'd8);
                take(d);
            end
            chk($sformatf("v%0d_drop", v), {63'd0, ov[d]}, 64'd0);
            chk_cnt($sformatf("v%0d_cnt", v), d);
        end

        // Back-pressure: block held stable while consumer stalls
        for (int j = 0; j < 8; j++) send(1, 8'(8'h31 + j), 1'b0);
        held = 64'h3132333435363738;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_in_ready", c), {63'd0, irdy[1]}, 64'd0);
            chk_out($sformatf("stall%0d", c), 1, held, 1'b0, 4'd0);
            @(negedge clk);
        end
        take(1);
        chk("after_stall_in_ready", {63'd0, irdy[1]}, 64'd1);
        send(1, 8'h41, 1'b1);
        chk_out("next_byte", 1, 64'h4107070707070707, 1'b1, 4'd7);
        take(1);

        // Stray out_ready and in_last without in_valid do nothing
        ordy[1] = 1'b1;
        il[1] = 1'b1;
        repeat (2) @(negedge clk);
        ordy[1] = 1'b0;
        il[1] = 1'b0;
        chk("stray_valid", {63'd0, ov[1]}, 64'd0);
        chk_cnt("stray_cnt", 1);
        send(1, 8'h55, 1'b1);
        chk_out("stray_blk", 1, 64'h5507070707070707, 1'b1, 4'd7);
        take(1);

        // Reset mid-block discards partial bytes
        send(1, 8'h01, 1'b0);
        send(1, 8'h02, 1'b0);
        send(1, 8'h03, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {63'd0, irdy[1]}, 64'd0);
        @(negedge clk);
        chk("mid_rst_block", ob[1], 64'd0);
        chk("mid_rst_valid", {63'd0, ov[1]}, 64'd0);
        chk("mid_rst_last", {63'd0, ol[1]}, 64'd0);
        chk("mid_rst_pad", {60'd0, op[1]}, 64'd0);
        cexp[0] = 0;
        cexp[1] = 0;
        chk_cnt("mid_rst_cnt0", 0);
        chk_cnt("mid_rst_cnt1", 1);
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) send(1, 8'(8'h21 + j), 1'b0);
        chk_out("post_rst", 1, 64'h2122232425262728, 1'b0, 4'd0);
        take(1);
        chk_cnt("post_rst_cnt", 1);

        // 3-bit counter wraps past 7
        for (int i = 0; i < 8; i++) begin
            send(1, 8'(i), 1'b1);
            take(1);
            chk_cnt($sformatf("wrap%0d_cnt", i), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
